// File: rtl/phase_generator.sv
// Phase accumulator feeding a Sine stage: advances a signed fixed-point phase by a
// programmable step on each accepted sample, folding it back into [-pi, pi).
module phase_generator #(
    parameter int INT_BITS     = 4,
    parameter int DECIMAL_BITS = 8,
    parameter int PI_FIXED     = 804,
    localparam int W           = INT_BITS + DECIMAL_BITS + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                step_load,
    input  logic signed [W-1:0] step_in,
    output logic signed [W-1:0] x,
    output logic                x_valid,
    input  logic                x_ready,
    output logic                wrap,
    output logic [15:0]         period_count,
    output logic                step_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic signed [W:0] PI_POS = (W+1)'(PI_FIXED);
    localparam logic signed [W:0] PI_NEG = -PI_POS;
    localparam logic signed [W:0] TWO_PI = (W+1)'(2 * PI_FIXED);

    state_t                state;
    state_t                stateNext;
    logic signed [W-1:0]   phase;
    logic signed [W-1:0]   step;
    logic signed [W-1:0]   phaseNext;
    logic signed [W:0]     sum;
    logic signed [W:0]     stepInExt;
    logic                  wrapNext;
    logic                  transfer;
    logic                  stepOk;
    logic [15:0]           periodCount;
    logic                  stepErr;

    assign x            = phase;
    assign period_count = periodCount;
    assign step_err     = stepErr;
    assign transfer     = x_valid && x_ready;

    // The step must stay strictly inside (-pi, pi) so a single fold always lands in range.
    assign stepInExt = (W+1)'(step_in);
    assign stepOk    = (stepInExt > PI_NEG) && (stepInExt < PI_POS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        stateNext = state;
        x_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                x_valid = 1'b1;
                if (stop) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        sum       = (W+1)'(phase) + (W+1)'(step);
        phaseNext = phase;
        wrapNext  = 1'b0;
        if (sum >= PI_POS) begin
            phaseNext = W'(sum - TWO_PI);
            wrapNext  = 1'b1;
        end else if (sum < PI_NEG) begin
            phaseNext = W'(sum + TWO_PI);
            wrapNext  = 1'b1;
        end else begin
            phaseNext = W'(sum);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= '0;
            step        <= '0;
            wrap        <= 1'b0;
            periodCount <= '0;
            stepErr     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (transfer) begin
                phase <= phaseNext;
                if (wrapNext) begin
                    wrap        <= 1'b1;
                    periodCount <= periodCount + 16'd1;
                end
            end
            if (step_load) begin
                if (stepOk) begin
                    step <= step_in;
                end else begin
                    stepErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_generator.sv
// Self-checking bench for phase_generator: directed scenarios plus random stimulus,
// all compared against an integer-arithmetic reference model.
module tb_phase_generator;

    localparam int PI = 804;
    localparam int W  = 13;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                stop;
    logic                step_load;
    logic signed [W-1:0] step_in;
    logic signed [W-1:0] x;
    logic                x_valid;
    logic                x_ready;
    logic                wrap;
    logic [15:0]         period_count;
    logic                step_err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    int mPhase;
    int mStep;
    int mWraps;
    bit mRun;
    bit mWrap;
    bit mErr;
    int wrapSeen;

    phase_generator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .step_load    (step_load),
        .step_in      (step_in),
        .x            (x),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .wrap         (wrap),
        .period_count (period_count),
        .step_err     (step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mStep  = 0;
        mWraps = 0;
        mRun   = 0;
        mWrap  = 0;
        mErr   = 0;
    endtask

    // Applies the behavioural rules for one rising edge using the current inputs.
    task automatic modelEdge();
        int s;
        mWrap = 0;
        if (mRun && x_ready) begin
            s = mPhase + mStep;
            if (s >= PI) begin
                s -= 2 * PI;
                mWrap = 1;
            end else if (s < -PI) begin
                s += 2 * PI;
                mWrap = 1;
            end
            if (mWrap) mWraps = (mWraps + 1) % 65536;
            mPhase = s;
        end
        if (step_load) begin
            if (int'(step_in) > -PI && int'(step_in) < PI) mStep = int'(step_in);
            else mErr = 1;
        end
        if (stop) mRun = 0;
        else if (start) mRun = 1;
    endtask

    task automatic compareAll();
        check("x_valid", int'(x_valid), int'(mRun));
        if (mRun) check("x", int'(x), mPhase);
        check("wrap", int'(wrap), int'(mWrap));
        check("period_count", int'(period_count), mWraps);
        check("step_err", int'(step_err), int'(mErr));
        if (wrap) wrapSeen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic drive(input bit st, input bit sp, input bit sl, input int si, input bit xr);
        start     = st;
        stop      = sp;
        step_load = sl;
        step_in   = W'(si);
        x_ready   = xr;
    endtask

    task automatic doReset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        modelReset();
        compareAll();
        rst = 1'b0;
        wrapSeen = 0;
    endtask

    // Reset, load a step and start; leaves x_valid=1 presenting phase 0.
    task automatic loadAndStart(input int stepVal);
        doReset();
        drive(0, 0, 1, stepVal, 1);
        cycle();
        drive(1, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        modelReset();
        #2;
        check("async_reset_x_valid", int'(x_valid), 0);
        check("async_reset_x", int'(x), 0);

        // Positive sweep with one wrap to -776
        loadAndStart(64);
        check("sweep_start_x", int'(x), 0);
        repeat (13) cycle();
        check("sweep_wrap_x", int'(x), -776);
        check("sweep_period", int'(period_count), 1);
        check("sweep_wrap_once", wrapSeen, 1);

        // Backpressure holds x at 192
        loadAndStart(64);
        repeat (3) cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_x", int'(x), 192);
        end
        drive(0, 0, 0, 0, 1);
        cycle();
        check("stall_release_x", int'(x), 256);

        // Negative sweep wrapping to 708
        loadAndStart(-100);
        repeat (8) cycle();
        check("neg_sweep_x", int'(x), -800);
        cycle();
        check("neg_wrap_x", int'(x), 708);
        check("neg_period", int'(period_count), 1);

        // Out-of-range step loads are rejected and stick
        loadAndStart(64);
        drive(0, 0, 1, 804, 1);
        cycle();
        drive(0, 0, 1, -804, 1);
        cycle();
        check("bad_step_err", int'(step_err), 1);
        drive(0, 0, 0, 0, 1);
        cycle();
        check("bad_step_unchanged_x", int'(x), 192);
        repeat (4) cycle();
        check("bad_step_sticky", int'(step_err), 1);

        // start+stop together in IDLE, then stop on a transfer cycle
        doReset();
        drive(0, 0, 1, 64, 0);
        cycle();
        drive(1, 1, 0, 0, 1);
        cycle();
        check("start_stop_idle", int'(x_valid), 0);
        drive(1, 0, 0, 0, 1);
        cycle();
        drive(0, 1, 0, 0, 1);
        cycle();
        check("stop_transfer_valid", int'(x_valid), 0);
        drive(1, 0, 0, 0, 0);
        cycle();
        check("stop_transfer_x", int'(x), 64);

        // Zero step never wraps
        loadAndStart(0);
        repeat (20) cycle();
        check("zero_step_wrap", wrapSeen, 0);
        check("zero_step_x", int'(x), 0);

        // Reset pulse between edges during RUN with wraps and step_err set
        loadAndStart(700);
        repeat (3) cycle();
        drive(0, 0, 1, 2000, 1);
        cycle();
        drive(0, 0, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_x", int'(x), 0);
        check("midrst_x_valid", int'(x_valid), 0);
        check("midrst_period", int'(period_count), 0);
        check("midrst_step_err", int'(step_err), 0);
        rst = 1'b0;
        modelReset();
        repeat (3) cycle();

        // Random stimulus against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(7) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(9) == 0), int'($urandom_range(2000)) - 1000,
                  ($urandom_range(3) != 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/phase_generator.md
PHASE_GENERATOR -- requirements
Module: phase_generator

Interface
REQ-001 SHALL have parameter INT_BITS, default 4, integer bits of the phase word.
REQ-002 SHALL have parameter DECIMAL_BITS, default 8, fractional bits of the phase word.
REQ-003 SHALL have parameter PI_FIXED, default 804, pi in fixed point, round(pi*2^DECIMAL_BITS).
REQ-004 SHALL define W = INT_BITS+DECIMAL_BITS+1, the two's-complement phase width; W-bit range SHALL hold ±2*PI_FIXED.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, begin producing samples.
REQ-008 SHALL have port stop, input, 1, cease producing samples.
REQ-009 SHALL have port step_load, input, 1, load step_in as the new phase increment.
REQ-010 SHALL have port step_in, input, W, signed two's-complement phase increment.
REQ-011 SHALL have port x, output, W, signed phase sample for the downstream Sine stage.
REQ-012 SHALL have port x_valid, output, 1, x holds a sample.
REQ-013 SHALL have port x_ready, input, 1, downstream accepts x.
REQ-014 SHALL have port wrap, output, 1, one-cycle pulse when the phase wraps.
REQ-015 SHALL have port period_count, output, 16, count of wraps, modulo 2^16.
REQ-016 SHALL have port step_err, output, 1, sticky flag for a rejected step load.

Function
REQ-017 SHALL implement two states, IDLE and RUN.
REQ-018 In IDLE, x_valid SHALL be 0 and phase SHALL hold.
REQ-019 start in IDLE SHALL move to RUN; x_valid SHALL be 1 from the next cycle, presenting the current phase.
REQ-020 A transfer SHALL occur on a cycle with x_valid=1 and x_ready=1.
REQ-021 On each transfer, phase SHALL advance by step at that edge, and x SHALL show the new phase the following cycle (one sample per cycle at full throughput).
REQ-022 While x_valid=1 and x_ready=0, x and phase SHALL stay stable.
REQ-023 stop in RUN SHALL move to IDLE at that edge; a transfer on the same cycle still completes and the phase still advances.
REQ-024 When start and stop are both asserted, stop SHALL win.
REQ-025 The advance SHALL compute sum = phase + step at W+1 bits.
REQ-026 If sum >= PI_FIXED, the next phase SHALL be sum - 2*PI_FIXED.
REQ-027 If sum < -PI_FIXED, the next phase SHALL be sum + 2*PI_FIXED.
REQ-028 Otherwise the next phase SHALL be sum; phase SHALL always stay within [-PI_FIXED, PI_FIXED).
REQ-029 On a wrap of either direction, wrap SHALL pulse high for the cycle after the edge and period_count SHALL increment, rolling over from 65535 to 0.
REQ-030 step_load SHALL be honoured in either state when -PI_FIXED < step_in < PI_FIXED.
REQ-031 A loaded step SHALL first apply to the advance after the load edge; an advance on the load cycle SHALL use the old step.
REQ-032 step_load with step_in outside that range SHALL leave step unchanged and set step_err, which SHALL clear only on reset.
REQ-033 With step = 0, phase SHALL stay constant and wrap SHALL never assert.
REQ-034 start in RUN and stop in IDLE SHALL have no effect.

Reset
REQ-035 While rst=1, outputs SHALL be forced immediately, independent of clk: x=0, x_valid=0, wrap=0, period_count=0, step_err=0.
REQ-036 While rst=1, internal state SHALL be forced immediately: phase=0, step=0, state=IDLE.
REQ-037 Assertion of rst mid-transfer SHALL discard the sample.
REQ-038 After rst deasserts, the first state change SHALL come from start or step_load on a later edge.

Verification
REQ-039 Reset, load step 64, start, x_ready=1 -> x = 0,64,...,768, then -776; wrap pulses once; period_count=1.
REQ-040 Running with step 64 and x_ready=0 for 5 cycles at x=192 -> x holds 192, no advance; on x_ready=1, next x=256.
REQ-041 From 0, load step -100 and run -> x = 0,-100,...,-800, then 708; wrap pulses; period_count increments.
REQ-042 step_load with step_in=804, then step_in=-804 -> step unchanged, step_err=1 and stays 1 until rst.
REQ-043 start and stop asserted together in IDLE -> stays IDLE, x_valid=0; stop on a transfer cycle in RUN -> phase advances once, then x_valid=0.
REQ-044 rst pulsed between clock edges during RUN -> x, x_valid, period_count and step_err read 0 before the next edge.
